// File: rtl/aes_round_ctrl_pkg.sv
// Shared phase codes and limits for the byte-serial AES-128 round sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_round_ctrl_pkg;

    // Phase code shared with the datapath; ADD_ROUND_KEY must stay 3'd1
    // because key_expansion decodes that value directly.
    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_ARK  = 3'd1,
        PH_SB   = 3'd2,
        PH_SR   = 3'd3,
        PH_MC   = 3'd4,
        PH_DONE = 3'd5
    } phase_t;

    // Rcon table depth bounds the round count.
    localparam int NR_MAX = 10;

    // cnt is 4 bits wide, so no phase may be longer than 16 cycles.
    localparam int PHASE_LEN_MAX = 16;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Host/datapath-facing control bundle of the AES round sequencer.
// Latency: n/a (wiring only).
// Backpressure: en_i from the host stalls every field carried here.
interface aes_round_ctrl_if;
    import aes_round_ctrl_pkg::*;

    logic       start_i;
    logic       en_i;
    logic       busy_o;
    logic       done_o;
    logic       key_load_o;
    phase_t     state_o;
    logic [3:0] round_o;
    logic [3:0] key_rnd_o;
    logic [3:0] cnt_o;

    // Host side: issues start/enable, observes schedule.
    modport master (
        output start_i, en_i,
        input  busy_o, done_o, key_load_o, state_o, round_o, key_rnd_o, cnt_o
    );

    // Sequencer side.
    modport slave (
        input  start_i, en_i,
        output busy_o, done_o, key_load_o, state_o, round_o, key_rnd_o, cnt_o
    );

endinterface

// File: rtl/aes_round_ctrl.sv
// Phase/round/cycle sequencer for the iterative byte-serial AES-128 encrypt core.
// Latency: busy for KE + (NR-1)(SB+1+MC+KE) + SB + 2 cycles after start, then 1-cycle done.
// Backpressure: en_i=0 freezes every register, so done/key_load pulses stretch until en_i returns.
module aes_round_ctrl
    import aes_round_ctrl_pkg::*;
#(
    parameter int NR        = 10,
    parameter int SB_CYCLES = 16,
    parameter int MC_CYCLES = 4,
    parameter int KE_CYCLES = 6
) (
    input  logic             clk,
    input  logic             rst,
    aes_round_ctrl_if.slave  ctrl
);

    // Parameters outside these bounds would overflow cnt/round or index Rcon out of range.
    if (NR < 1 || NR > NR_MAX ||
        SB_CYCLES < 1 || SB_CYCLES > PHASE_LEN_MAX ||
        MC_CYCLES < 1 || MC_CYCLES > PHASE_LEN_MAX ||
        KE_CYCLES < 1 || KE_CYCLES > PHASE_LEN_MAX) begin : g_bad_param
        $error("aes_round_ctrl: illegal parameter set");
    end

    localparam logic [3:0] NR_L    = 4'(NR);
    localparam logic [3:0] SB_LAST = 4'(SB_CYCLES - 1);
    localparam logic [3:0] MC_LAST = 4'(MC_CYCLES - 1);
    localparam logic [3:0] KE_LAST = 4'(KE_CYCLES - 1);

    phase_t     phase_q, phase_d;
    logic [3:0] round_q, round_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       key_load_q, key_load_d;
    logic [3:0] cnt_last;

    // Final cnt value of the current phase; last-round ARK is a single cycle
    // because there is no further key to write back.
    always_comb begin
        cnt_last = 4'd0;
        case (phase_q)
            PH_ARK:  cnt_last = (round_q == NR_L) ? 4'd0 : KE_LAST;
            PH_SB:   cnt_last = SB_LAST;
            PH_MC:   cnt_last = MC_LAST;
            default: cnt_last = 4'd0;
        endcase
    end

    // Next-state logic: everything holds unless en_i is high.
    always_comb begin
        phase_d    = phase_q;
        round_d    = round_q;
        cnt_d      = cnt_q;
        key_load_d = key_load_q;
        if (ctrl.en_i) begin
            key_load_d = 1'b0;
            case (phase_q)
                PH_IDLE: begin
                    if (ctrl.start_i) begin
                        phase_d    = PH_ARK;
                        round_d    = 4'd0;
                        cnt_d      = 4'd0;
                        key_load_d = 1'b1;
                    end
                end
                PH_DONE: begin
                    phase_d = PH_IDLE;
                    round_d = 4'd0;
                    cnt_d   = 4'd0;
                end
                default: begin
                    if (cnt_q != cnt_last) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d = 4'd0;
                        case (phase_q)
                            PH_ARK: begin
                                if (round_q == NR_L) begin
                                    phase_d = PH_DONE;
                                end else begin
                                    round_d = round_q + 4'd1;
                                    phase_d = PH_SB;
                                end
                            end
                            PH_SB:   phase_d = PH_SR;
                            PH_SR:   phase_d = (round_q == NR_L) ? PH_ARK : PH_MC;
                            PH_MC:   phase_d = PH_ARK;
                            default: phase_d = PH_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // Schedule registers; reset discards any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= PH_IDLE;
            round_q    <= 4'd0;
            cnt_q      <= 4'd0;
            key_load_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            round_q    <= round_d;
            cnt_q      <= cnt_d;
            key_load_q <= key_load_d;
        end
    end

    // Outputs decode from registered state only.
    assign ctrl.state_o    = phase_q;
    assign ctrl.round_o    = round_q;
    assign ctrl.cnt_o      = cnt_q;
    assign ctrl.key_load_o = key_load_q;
    assign ctrl.done_o     = (phase_q == PH_DONE);
    assign ctrl.busy_o     = (phase_q != PH_IDLE) && (phase_q != PH_DONE);
    assign ctrl.key_rnd_o  = (phase_q == PH_ARK && round_q != NR_L) ? (round_q + 4'd1) : 4'd0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for the AES round sequencer: reset, trace, stall, ignored start, abort.
// Latency: n/a.
// Backpressure: en_i driven by the bench.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(
        .NR        (10),
        .SB_CYCLES (16),
        .MC_CYCLES (4),
        .KE_CYCLES (6)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Expected per-cycle {state, round, cnt, key_rnd}.
    logic [14:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] obs_vec();
        return {bus.state_o, bus.round_o, bus.cnt_o, bus.key_rnd_o};
    endfunction

    function automatic void push(input int ph, input int r, input int c);
        int krnd;
        krnd = (ph == 1 && r < 10) ? r + 1 : 0;
        exp_q.push_back({3'(ph), 4'(r), 4'(c), 4'(krnd)});
    endfunction

    // Hand-written schedule for NR=10, SB=16, MC=4, KE=6.
    function automatic void build_trace();
        exp_q.delete();
        for (int c = 0; c < 6; c++) push(1, 0, c);
        for (int r = 1; r < 10; r++) begin
            for (int c = 0; c < 16; c++) push(2, r, c);
            push(3, r, 0);
            for (int c = 0; c < 4; c++) push(4, r, c);
            for (int c = 0; c < 6; c++) push(1, r, c);
        end
        for (int c = 0; c < 16; c++) push(2, 10, c);
        push(3, 10, 0);
        push(1, 10, 0);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " state"},    bus.state_o,    32'd0);
        chk({tag, " round"},    bus.round_o,    32'd0);
        chk({tag, " cnt"},      bus.cnt_o,      32'd0);
        chk({tag, " key_rnd"},  bus.key_rnd_o,  32'd0);
        chk({tag, " busy"},     bus.busy_o,     32'd0);
        chk({tag, " done"},     bus.done_o,     32'd0);
        chk({tag, " key_load"}, bus.key_load_o, 32'd0);
    endtask

    // Entered at the negedge right after the accepting edge. Walks the busy
    // window comparing the trace, optionally stalling and pulsing start_i.
    task automatic run_block(input string tag, input int stall_at, input int stall_len,
                             input int pulse_at, output int busy_cnt);
        int idx;
        int guard;
        build_trace();
        idx      = 0;
        guard    = 0;
        busy_cnt = 0;
        while (bus.busy_o === 1'b1 && guard < 2000) begin
            guard++;
            busy_cnt++;
            if (idx < exp_q.size())
                chk({tag, " trace"}, obs_vec(), exp_q[idx]);
            else
                chk({tag, " overrun"}, idx, exp_q.size());
            chk({tag, " key_load"}, bus.key_load_o, (idx == 0));
            if (idx == stall_at) begin
                bus.en_i = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    busy_cnt++;
                    chk({tag, " frozen"}, obs_vec(), exp_q[idx]);
                    chk({tag, " frozen key_load"}, bus.key_load_o, (idx == 0));
                    chk({tag, " frozen busy"}, bus.busy_o, 32'd1);
                end
                bus.en_i = 1'b1;
            end
            bus.start_i = (idx == pulse_at);
            idx++;
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        chk({tag, " busy bounded"}, (guard < 2000), 32'd1);
        chk({tag, " trace length"}, idx, 32'd267);
        chk({tag, " done"},  bus.done_o,  32'd1);
        chk({tag, " done state"}, bus.state_o, 32'd5);
    endtask

    task automatic do_start();
        bus.start_i = 1'b1;
        bus.en_i    = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    int bc;

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.en_i    = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset("idle");

        // start with en_i low is ignored
        bus.en_i    = 1'b0;
        bus.start_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("noen state",    bus.state_o,    32'd0);
        chk("noen key_load", bus.key_load_o, 32'd0);
        chk("noen busy",     bus.busy_o,     32'd0);

        // nominal run with full phase trace
        do_start();
        run_block("nominal", -1, 0, -1, bc);
        chk("nominal busy cycles", bc, 32'd267);
        @(negedge clk);
        chk("nominal idle", bus.state_o, 32'd0);
        chk("nominal done low", bus.done_o, 32'd0);

        // stall at SB r3 cnt9 (trace index 69) for 7 cycles
        do_start();
        run_block("stall", 69, 7, -1, bc);
        chk("stall busy cycles", bc, 32'd274);
        @(negedge clk);
        chk("stall idle", bus.state_o, 32'd0);

        // stall on first cycle (key_load held), start pulse in MC r5 cnt1 (index 132)
        do_start();
        run_block("ignore", 0, 3, 132, bc);
        chk("ignore busy cycles", bc, 32'd270);
        // done held while en_i low, start in DONE ignored
        bus.en_i    = 1'b0;
        bus.start_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("done held", bus.done_o, 32'd1);
        chk("done held state", bus.state_o, 32'd5);
        bus.en_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("after done state", bus.state_o, 32'd0);
        chk("after done done", bus.done_o, 32'd0);
        chk("after done key_load", bus.key_load_o, 32'd0);
        @(negedge clk);
        chk("no queued start", bus.state_o, 32'd0);
        chk("no queued busy", bus.busy_o, 32'd0);

        // abort at ARK r4 cnt2 (index 110), then a clean run
        do_start();
        repeat (110) @(negedge clk);
        chk("abort point state", bus.state_o, 32'd1);
        chk("abort point round", bus.round_o, 32'd4);
        chk("abort point cnt",   bus.cnt_o,   32'd2);
        #2 rst = 1'b1;
        #1;
        chk_reset("async reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("post abort");
        do_start();
        run_block("restart", -1, 0, -1, bc);
        chk("restart busy cycles", bc, 32'd267);
        @(negedge clk);
        chk("restart idle", bus.state_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
